pixel_buffer_reader: RTL and testbench

- Downstream read stage of the LocalBuffer pixel SRAM (1024 x 48-bit dual-port, 3 x 16-bit lanes).
- Drives read port A only.
- Once started, walks a rectangular region (rows x cols, arbitrary row stride from a base address) and streams each 48-bit word to the compute datapath over a valid/ready interface.
- Absorbs the one-cycle SRAM read latency with a small output FIFO, so full throughput (one word per cycle) is sustained while the consumer stays ready.

---
 rtl/pixel_buffer_reader.sv | 184 ++++++++++++++++++
 tb/tb_pixel_buffer_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_buffer_reader.sv
// pixel_buffer_reader: walks a rectangular region of the LocalBuffer pixel
// SRAM via read port A and streams each 48-bit word to the compute datapath.
// A small output FIFO absorbs the one-cycle SRAM read latency so one word per
// cycle is sustained while the consumer stays ready.
//
// Handshake: pix_valid is high whenever the FIFO holds a word. A word is
// transferred on every rising edge where pix_valid & pix_ready are both high.
// While pix_valid=1 and pix_ready=0, pix_data/pix_eol/pix_last hold steady.
// pix_valid never depends on pix_ready.
module pixel_buffer_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 48,
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] cols,
  input  logic [ADDR_W-1:0] rows,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_oea,
  output logic [2:0]        sram_wean,
  input  logic [DATA_W-1:0] sram_doa,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_last,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_fifo_count,
  output logic              dbg_inflight
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0]    DEPTH_V  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cols_q, rows_q, stride_q;
  logic [ADDR_W-1:0] addr_q, row_addr_q, col_q, row_q;
  logic              empty_q;
  logic              inflight_q, inflight_eol_q, inflight_last_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]     data_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] eol_mem_q, last_mem_q;

  logic              pop, push, issue, is_eol, is_last;
  logic [CNT_W:0]    occ_after;
  logic [CNT_W-1:0]  count_d;
  logic [ADDR_W-1:0] next_row_addr;

  // A read may be issued only if its word will still fit once it lands.
  assign pop           = (count_q != '0) && pix_ready;
  assign push          = inflight_q;
  assign occ_after     = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue         = (state_q == S_RUN) && !empty_q && (occ_after < DEPTH_V);
  assign is_eol        = (col_q == cols_q - ADDR_ONE);
  assign is_last       = is_eol && (row_q == rows_q - ADDR_ONE);
  assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
  assign next_row_addr = row_addr_q + stride_q;

  assign sram_a    = addr_q;
  assign sram_oea  = issue || inflight_q;
  assign sram_wean = 3'b111;

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pix_valid = (count_q != '0);
  assign pix_data  = data_mem_q[rd_ptr_q];
  assign pix_eol   = pix_valid && eol_mem_q[rd_ptr_q];
  assign pix_last  = pix_valid && last_mem_q[rd_ptr_q];

  assign dbg_state      = state_q;
  assign dbg_fifo_count = count_q;
  assign dbg_inflight   = inflight_q;

  // Control FSM with region walk counters and the in-flight read tag.
  // An empty region still spends one busy cycle in RUN before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cols_q          <= '0;
      rows_q          <= '0;
      stride_q        <= '0;
      addr_q          <= '0;
      row_addr_q      <= '0;
      col_q           <= '0;
      row_q           <= '0;
      empty_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_eol_q  <= 1'b0;
      inflight_last_q <= 1'b0;
      count_q         <= '0;
    end else begin
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        inflight_eol_q  <= is_eol;
        inflight_last_q <= is_last;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cols_q     <= cols;
            rows_q     <= rows;
            stride_q   <= row_stride;
            addr_q     <= base_addr;
            row_addr_q <= base_addr;
            col_q      <= '0;
            row_q      <= '0;
            empty_q    <= (rows == '0) || (cols == '0);
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (empty_q) begin
            state_q <= S_DONE;
          end else if (issue) begin
            if (is_eol) begin
              row_addr_q <= next_row_addr;
              addr_q     <= next_row_addr;
              col_q      <= '0;
              row_q      <= row_q + ADDR_ONE;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
              col_q  <= col_q + ADDR_ONE;
            end
            if (is_last) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (count_d == '0) begin
            state_q <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers: write on capture of the read data, read on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FIFO storage: SRAM word plus its row/region tags.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= sram_doa;
      eol_mem_q[wr_ptr_q]  <= inflight_eol_q;
      last_mem_q[wr_ptr_q] <= inflight_last_q;
    end
  end

endmodule

// File: tb/tb_pixel_buffer_reader.sv
// Bench for pixel_buffer_reader: SRAM model, region reference model, timing
// and handshake checks, occupancy monitor.
module tb_pixel_buffer_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 48;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] cols = '0;
  logic [ADDR_W-1:0] rows = '0;
  logic [ADDR_W-1:0] row_stride = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] sram_a;
  logic              sram_oea;
  logic [2:0]        sram_wean;
  logic [DATA_W-1:0] sram_doa = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              pix_eol, pix_last;
  logic [1:0]        dbg_state;
  logic [1:0]        dbg_fifo_count;
  logic              dbg_inflight;

  logic [DATA_W-1:0] sram_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en    = 1'b0;
  bit prev_full = 1'b0;

  logic [DATA_W-1:0] exp_q[$];
  bit                exp_eol_q[$];
  bit                exp_last_q[$];

  pixel_buffer_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_addr(base_addr), .cols(cols), .rows(rows), .row_stride(row_stride),
    .busy(busy), .done(done),
    .sram_a(sram_a), .sram_oea(sram_oea), .sram_wean(sram_wean), .sram_doa(sram_doa),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_last(pix_last),
    .dbg_state(dbg_state), .dbg_fifo_count(dbg_fifo_count), .dbg_inflight(dbg_inflight)
  );

  // Clock
  always #5 clk = ~clk;

  // SRAM port A: one-cycle read latency.
  always @(posedge clk) begin
    if (sram_oea) sram_doa <= sram_mem[sram_a];
  end

  function automatic logic [DATA_W-1:0] word_of(input int a);
    logic [15:0] o;
    o = 16'(a);
    return {16'hA000 + o, 16'hB000 + o, 16'hC000 + o};
  endfunction

  function automatic logic ready_of(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // Occupancy monitor: no overflow, no read issued into a full buffer.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_full = 1'b0;
    end else begin
      int occ;
      bit popv;
      popv = pix_valid && pix_ready;
      occ  = int'(dbg_fifo_count) + int'(dbg_inflight) - int'(popv);
      n_checks++;
      if (dbg_fifo_count > 2'(DEPTH) || (int'(dbg_fifo_count) == DEPTH && dbg_inflight && !popv) ||
          (prev_full && dbg_inflight) || (occ >= DEPTH && !dbg_inflight && sram_oea)) begin
        n_fail++;
        $display("FAIL occupancy t=%0t: count=%0d inflight=%0d pop=%0d prev_full=%0d oea=%0d, required count<=%0d and no issue into a full buffer",
                 $time, dbg_fifo_count, dbg_inflight, popv, prev_full, sram_oea, DEPTH);
      end
      prev_full = (occ >= DEPTH);
    end
  end

  // Runs one region; cycle 0 is the start cycle. Optional stray starts with
  // junk config at glitch_cyc and in the expected DONE cycle.
  task automatic run_frame(input int base, input int ncols, input int nrows, input int stride,
                           input int mode, input int glitch_cyc, input bit start_at_done,
                           input string name);
    int n, budget, first_valid, done_cycle, last_pop, busy_bad, idx;
    bit oea_seen, prev_stall;
    logic [DATA_W-1:0] prev_data, ed;
    logic prev_eol, prev_last;
    bit ee, el;
    exp_q.delete();
    exp_eol_q.delete();
    exp_last_q.delete();
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < ncols; c++) begin
        exp_q.push_back(word_of((base + r * stride + c) % 1024));
        exp_eol_q.push_back(c == ncols - 1);
        exp_last_q.push_back((c == ncols - 1) && (r == nrows - 1));
      end
    end
    n = nrows * ncols;
    budget = 20 * n + 40;
    first_valid = -1; done_cycle = -1; last_pop = -1; busy_bad = 0; idx = 0;
    oea_seen = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_eol = 1'b0; prev_last = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        base_addr = ADDR_W'(base); cols = ADDR_W'(ncols); rows = ADDR_W'(nrows);
        row_stride = ADDR_W'(stride); start = 1'b1;
      end else if (k == glitch_cyc || (start_at_done && k == n + 3)) begin
        base_addr = ADDR_W'(base + 100); cols = 10'd7; rows = 10'd7; row_stride = 10'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      pix_ready = ready_of(mode, k);
      @(negedge clk);
      if (sram_oea) oea_seen = 1'b1;
      if (pix_valid && first_valid < 0) first_valid = k;
      if (prev_stall) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data !== prev_data || pix_eol !== prev_eol || pix_last !== prev_last) begin
          n_fail++;
          $display("FAIL %s stall_hold cycle %0d: got valid=%0d data=%h eol=%0d last=%0d, required valid=1 data=%h eol=%0d last=%0d",
                   name, k, pix_valid, pix_data, pix_eol, pix_last, prev_data, prev_eol, prev_last);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data = pix_data; prev_eol = pix_eol; prev_last = pix_last;
      if (pix_valid && pix_ready) begin
        last_pop = k;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_word cycle %0d: got data=%h, required no further word", name, k, pix_data);
        end else begin
          ed = exp_q.pop_front(); ee = exp_eol_q.pop_front(); el = exp_last_q.pop_front();
          if (pix_data !== ed || pix_eol !== ee || pix_last !== el) begin
            n_fail++;
            $display("FAIL %s word[%0d]: got data=%h eol=%0d last=%0d, required data=%h eol=%0d last=%0d",
                     name, idx, pix_data, pix_eol, pix_last, ed, ee, el);
          end
        end
        idx++;
      end
      if (done) begin
        if (busy !== 1'b0) busy_bad++;
        done_cycle = k;
        break;
      end else if (k >= 1 && busy !== 1'b1) begin
        busy_bad++;
      end else if (k == 0 && busy !== 1'b0) begin
        busy_bad++;
      end
    end
    n_checks++;
    if (done_cycle < 0) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done within %0d cycles, required one done pulse", name, budget);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_words: got %0d words, required %0d", name, idx, n);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy: got %0d cycles with wrong busy, required 0", name, busy_bad);
    end
    if (n > 0) begin
      n_checks++;
      if (done_cycle != last_pop + 1) begin
        n_fail++;
        $display("FAIL %s done_after_last: got done at cycle %0d, required %0d", name, done_cycle, last_pop + 1);
      end
      if (mode == 0) begin
        n_checks++;
        if (first_valid != 3 || done_cycle != n + 3) begin
          n_fail++;
          $display("FAIL %s latency: got first_valid=%0d done=%0d, required first_valid=3 done=%0d",
                   name, first_valid, done_cycle, n + 3);
        end
      end
    end else begin
      n_checks++;
      if (done_cycle != 2 || oea_seen || first_valid >= 0) begin
        n_fail++;
        $display("FAIL %s degenerate: got done=%0d oea_seen=%0d first_valid=%0d, required done=2 oea_seen=0 first_valid=-1",
                 name, done_cycle, oea_seen, first_valid);
      end
    end
  endtask

  task automatic idle_check(input string name, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (busy || done || pix_valid || sram_oea) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d active cycles (busy/done/valid/oea), required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0 || pix_eol !== 1'b0 || pix_last !== 1'b0 ||
        sram_oea !== 1'b0 || sram_a !== '0 || sram_wean !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%0d done=%0d valid=%0d eol=%0d last=%0d oea=%0d a=%0d wean=%b, required all 0 and wean=111",
               busy, done, pix_valid, pix_eol, pix_last, sram_oea, sram_a, sram_wean);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(0, 4, 2, 8, 0, -1, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    run_frame(0, 4, 2, 8, 1, -1, 1'b0, "backpressure");
  endtask

  task automatic test_wrap();
    run_frame(1022, 3, 2, 4, 0, -1, 1'b0, "wrap");
  endtask

  task automatic test_degenerate();
    run_frame(5, 4, 0, 3, 0, -1, 1'b0, "rows_zero");
    run_frame(5, 0, 3, 3, 0, -1, 1'b0, "cols_zero");
  endtask

  task automatic test_start_ignored();
    run_frame(100, 3, 3, 10, 0, 5, 1'b1, "start_ignored");
    idle_check("no_extra_frame", 6);
  endtask

  task automatic test_back_to_back();
    run_frame(200, 2, 2, 5, 0, -1, 1'b0, "b2b_first");
    run_frame(300, 3, 2, 7, 0, -1, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 1023)), 2, -1, 1'b0, "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    int pops, bad;
    pops = 0; bad = 0;
    @(posedge clk);
    #1;
    base_addr = 10'd40; cols = 10'd4; rows = 10'd4; row_stride = 10'd16;
    start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 40 && pops < 3; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      if (pix_valid && pix_ready) pops++;
    end
    n_checks++;
    if (pops != 3) begin
      n_fail++;
      $display("FAIL midreset_prefix: got %0d words, required 3", pops);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0 || pix_eol !== 1'b0 || pix_last !== 1'b0 ||
        sram_oea !== 1'b0 || sram_a !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%0d done=%0d valid=%0d eol=%0d last=%0d oea=%0d a=%0d, required all 0",
               busy, done, pix_valid, pix_eol, pix_last, sram_oea, sram_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || pix_valid) bad++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy || pix_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d cycles with done/busy/valid, required 0", bad);
    end
    run_frame(40, 4, 4, 16, 0, -1, 1'b0, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = word_of(i);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_degenerate();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
